// File: rtl/reg_result_checker_pkg.sv
// Shared definitions for the register result checker.
//   - Default widths and sizes for the checker and its compare stage.
//   - state_e: checker FSM state encoding (3-bit, IDLE=0 .. DONE=4).
package reg_result_checker_pkg;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int NUM_REGS_DEF   = 32;
    localparam int RUN_CYCLES_DEF = 50;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_SCAN  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/reg_result_checker_cmp_stage.sv
// reg_cmp_stage: one-cycle compare/accumulate pipeline behind the scan.
// The address-issue strobe and index are delayed one cycle so they line up
// with the 1-cycle-latency register-file and ROM read data.
// Ports:
//   clk, rst        clock / asynchronous active-high reset
//   clear           synchronous clear of all results (entry to RUN)
//   issue           an address is being issued this cycle
//   issue_idx       index of the address being issued
//   rf_rdata        register value for the address issued last cycle
//   exp_data        expected value for the address issued last cycle
//   match_cnt       number of matching registers so far
//   match_cnt_next  value match_cnt takes at the next edge
//   mism_seen       at least one mismatch recorded
//   mism_idx        index of the first mismatching register
module reg_cmp_stage
    import reg_result_checker_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_REGS   = NUM_REGS_DEF,
    localparam int AW        = $clog2(NUM_REGS),
    localparam int CW        = $clog2(NUM_REGS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  issue,
    input  logic [AW-1:0]         issue_idx,
    input  logic [DATA_WIDTH-1:0] rf_rdata,
    input  logic [DATA_WIDTH-1:0] exp_data,
    output logic [CW-1:0]         match_cnt,
    output logic [CW-1:0]         match_cnt_next,
    output logic                  mism_seen,
    output logic [AW-1:0]         mism_idx
);

    localparam logic [CW-1:0] CNT_FULL = CW'(NUM_REGS);

    logic          cmp_valid_q, cmp_valid_d;
    logic [AW-1:0] cmp_idx_q,   cmp_idx_d;
    logic [CW-1:0] match_cnt_q, match_cnt_d;
    logic          mism_seen_q, mism_seen_d;
    logic [AW-1:0] mism_idx_q,  mism_idx_d;

    always_comb begin
        cmp_valid_d = issue;
        cmp_idx_d   = issue_idx;
        match_cnt_d = match_cnt_q;
        mism_seen_d = mism_seen_q;
        mism_idx_d  = mism_idx_q;
        if (clear) begin
            match_cnt_d = '0;
            mism_seen_d = 1'b0;
            mism_idx_d  = '0;
        end else if (cmp_valid_q) begin
            if (rf_rdata == exp_data) begin
                // Saturate so the count can never wrap past NUM_REGS.
                if (match_cnt_q != CNT_FULL) begin
                    match_cnt_d = match_cnt_q + 1'b1;
                end
            end else if (!mism_seen_q) begin
                // Only the first mismatch is kept.
                mism_seen_d = 1'b1;
                mism_idx_d  = cmp_idx_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_valid_q <= 1'b0;
            cmp_idx_q   <= '0;
            match_cnt_q <= '0;
            mism_seen_q <= 1'b0;
            mism_idx_q  <= '0;
        end else begin
            cmp_valid_q <= cmp_valid_d;
            cmp_idx_q   <= cmp_idx_d;
            match_cnt_q <= match_cnt_d;
            mism_seen_q <= mism_seen_d;
            mism_idx_q  <= mism_idx_d;
        end
    end

    assign match_cnt      = match_cnt_q;
    assign match_cnt_next = match_cnt_d;
    assign mism_seen      = mism_seen_q;
    assign mism_idx       = mism_idx_q;

endmodule

// File: rtl/reg_result_checker.sv
// reg_result_checker: after start, lets the core run RUN_CYCLES clocks,
// then holds the core and scans every architectural register against an
// expected-value ROM, reporting match count, first mismatch and pass/done.
// Ports:
//   clk, rst     clock / asynchronous active-high reset
//   start        1-cycle pulse, honoured only in IDLE or DONE
//   core_hold    freezes the core during SCAN and DRAIN
//   rf_raddr     debug read address into the core register file
//   rf_rdata     register value (1-cycle read latency)
//   exp_addr     expected-ROM address (same as rf_raddr)
//   exp_data     expected value (1-cycle read latency)
//   busy         high in RUN, SCAN, DRAIN
//   done         high in DONE
//   pass         all registers matched (valid with done)
//   match_cnt    number of matching registers
//   mism_seen    at least one mismatch recorded
//   mism_idx     index of the first mismatching register
module reg_result_checker
    import reg_result_checker_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int RUN_CYCLES = RUN_CYCLES_DEF,
    localparam int AW        = $clog2(NUM_REGS),
    localparam int CW        = $clog2(NUM_REGS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  core_hold,
    output logic [AW-1:0]         rf_raddr,
    input  logic [DATA_WIDTH-1:0] rf_rdata,
    output logic [AW-1:0]         exp_addr,
    input  logic [DATA_WIDTH-1:0] exp_data,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CW-1:0]         match_cnt,
    output logic                  mism_seen,
    output logic [AW-1:0]         mism_idx
);

    localparam int RW = $clog2(RUN_CYCLES + 1);
    localparam logic [RW-1:0] RUN_LAST = RW'(RUN_CYCLES - 1);
    localparam logic [AW-1:0] IDX_LAST = AW'(NUM_REGS - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(NUM_REGS);

    state_e        state_q,   state_d;
    logic [RW-1:0] run_cnt_q, run_cnt_d;
    logic [AW-1:0] idx_q,     idx_d;
    logic          pass_q,    pass_d;

    logic          clear_results;
    logic          issue;
    logic [CW-1:0] match_cnt_next;

    always_comb begin
        state_d       = state_q;
        run_cnt_d     = run_cnt_q;
        idx_d         = idx_q;
        pass_d        = pass_q;
        clear_results = 1'b0;
        issue         = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d       = ST_RUN;
                    run_cnt_d     = '0;
                    idx_d         = '0;
                    pass_d        = 1'b0;
                    clear_results = 1'b1;
                end
            end
            ST_RUN: begin
                if (run_cnt_q == RUN_LAST) begin
                    state_d   = ST_SCAN;
                    run_cnt_d = '0;
                end else begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
            end
            ST_SCAN: begin
                issue = 1'b1;
                // idx stays at the last index through DRAIN.
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DRAIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // The last compare retires on this edge, so judge pass on
                // the count being written rather than the registered one.
                state_d = ST_DONE;
                idx_d   = '0;
                pass_d  = (match_cnt_next == CNT_FULL);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            run_cnt_q <= '0;
            idx_q     <= '0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            idx_q     <= idx_d;
            pass_q    <= pass_d;
        end
    end

    reg_cmp_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_cmp (
        .clk            (clk),
        .rst            (rst),
        .clear          (clear_results),
        .issue          (issue),
        .issue_idx      (idx_q),
        .rf_rdata       (rf_rdata),
        .exp_data       (exp_data),
        .match_cnt      (match_cnt),
        .match_cnt_next (match_cnt_next),
        .mism_seen      (mism_seen),
        .mism_idx       (mism_idx)
    );

    assign core_hold = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_SCAN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign rf_raddr  = idx_q;
    assign exp_addr  = idx_q;

endmodule

// File: tb/tb_reg_result_checker.sv
module tb_reg_result_checker;

    localparam int DW = 64;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          core_hold;
    logic [4:0]    rf_raddr;
    logic [DW-1:0] rf_rdata;
    logic [4:0]    exp_addr;
    logic [DW-1:0] exp_data;
    logic          busy;
    logic          done;
    logic          pass;
    logic [5:0]    match_cnt;
    logic          mism_seen;
    logic [4:0]    mism_idx;

    reg_result_checker #(
        .DATA_WIDTH (64),
        .NUM_REGS   (32),
        .RUN_CYCLES (50)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .core_hold (core_hold),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .exp_addr  (exp_addr),
        .exp_data  (exp_data),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .match_cnt (match_cnt),
        .mism_seen (mism_seen),
        .mism_idx  (mism_idx)
    );

    always #5 clk = ~clk;

    // Register file and expected ROM, both with 1-cycle read latency.
    logic [DW-1:0] rf_mem  [NR];
    logic [DW-1:0] rom_mem [NR];
    always @(posedge clk) begin
        rf_rdata <= rf_mem[rf_raddr];
        exp_data <= rom_mem[exp_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int         start_cyc;
        logic       pass;
        logic [5:0] cnt;
        logic       seen;
        logic [4:0] idx;
        string      tag;
    } exp_t;

    exp_t sb[$];

    // Monitor: checks the front run's timing, address sequence and results.
    int mon_k;
    int mon_a;
    always @(negedge clk) begin
        if (!rst && sb.size() > 0) begin
            mon_k = cyc - sb[0].start_cyc;
            if (mon_k >= 1 && mon_k <= 50) begin
                chk("run_hold", core_hold, 0);
                chk("run_busy", busy, 1);
                chk("run_cleared", {done, pass, mism_seen, match_cnt}, 0);
            end else if (mon_k >= 51 && mon_k <= 83) begin
                mon_a = (mon_k - 51 > 31) ? 31 : mon_k - 51;
                chk("scan_hold", core_hold, 1);
                chk("scan_busy", busy, 1);
                chk("rf_raddr", rf_raddr, mon_a);
                chk("exp_addr", exp_addr, mon_a);
            end else if (mon_k == 84) begin
                chk("done_flag", done, 1);
                chk("done_hold", core_hold, 0);
                chk("done_busy", busy, 0);
                chk("done_addr", rf_raddr, 0);
                chk("pass", pass, sb[0].pass);
                chk("match_cnt", match_cnt, sb[0].cnt);
                chk("mism_seen", mism_seen, sb[0].seen);
                chk("mism_idx", mism_idx, sb[0].idx);
                $display("[TB] %s: done@+%0d pass=%0d match_cnt=%0d mism_seen=%0d mism_idx=%0d",
                         sb[0].tag, mon_k, pass, match_cnt, mism_seen, mism_idx);
                void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input string tag, input logic p, input logic [5:0] c,
                            input logic s, input logic [4:0] i);
        exp_t e;
        tick();
        start = 1'b1;
        e.start_cyc = cyc;
        e.pass = p; e.cnt = c; e.seen = s; e.idx = i; e.tag = tag;
        sb.push_back(e);
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_at(input int target);
        while (cyc < target) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("run_timeout", sb.size(), 0);
        sb.delete();
        tick();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_hold"}, core_hold, 0);
        chk({tag, "_addr"}, {rf_raddr, exp_addr}, 0);
        chk({tag, "_flags"}, {busy, done, pass, mism_seen}, 0);
        chk({tag, "_cnt"}, match_cnt, 0);
        chk({tag, "_idx"}, mism_idx, 0);
    endtask

    task automatic fill_match();
        for (int i = 0; i < NR; i++) begin
            rf_mem[i]  = 64'h0123_4567_0000_0000 + 64'(i) * 64'h0000_0001_0001_0001;
            rom_mem[i] = rf_mem[i];
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int s0;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        fill_match();
        repeat (3) tick();
        @(negedge clk);
        check_zero("reset_held");
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_zero("reset_out");

        // 1: all registers match.
        do_start("t1_all_match", 1'b1, 6'd32, 1'b0, 5'd0);
        wait_idle();

        // 2: x5 and bit 63 of x20 differ.
        rom_mem[5] = 64'h1;
        rf_mem[5]  = 64'h0;
        rf_mem[20] = rom_mem[20] ^ 64'h8000_0000_0000_0000;
        do_start("t2_two_mism", 1'b0, 6'd30, 1'b1, 5'd5);
        wait_idle();

        // 3: only x0 differs.
        fill_match();
        rf_mem[0]  = 64'h0;
        rom_mem[0] = 64'hDEAD;
        do_start("t3_x0_mism", 1'b0, 6'd31, 1'b1, 5'd0);
        wait_idle();

        // 4: reset during SCAN at idx=10 (after x3 already mismatched).
        fill_match();
        rf_mem[3] = 64'h0;
        do_start("t4_aborted", 1'b0, 6'd31, 1'b1, 5'd3);
        s0 = sb[0].start_cyc;
        while (cyc < s0 + 61) tick();
        chk("pre_rst_addr", rf_raddr, 10);
        chk("pre_rst_seen", mism_seen, 1);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check_zero("mid_rst");
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_zero("after_rst");
        fill_match();
        do_start("t4_restart", 1'b1, 6'd32, 1'b0, 5'd0);
        wait_idle();

        // 5: starts during RUN, SCAN and DRAIN are ignored; start in DONE restarts.
        do_start("t5_ignored_starts", 1'b1, 6'd32, 1'b0, 5'd0);
        s0 = sb[0].start_cyc;
        pulse_at(s0 + 20);
        pulse_at(s0 + 60);
        pulse_at(s0 + 83);
        wait_idle();
        rf_mem[31] = ~rom_mem[31];
        do_start("t5_rerun", 1'b0, 6'd31, 1'b1, 5'd31);
        wait_idle();
        repeat (3) tick();
        @(negedge clk);
        chk("done_held", {done, busy, core_hold}, 3'b100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
